// File: rtl/rx_ser2par_align_pkg.sv
// rx_ser2par_align_pkg: K28.5 comma codes and alignment FSM states shared by the receive path.
package rx_ser2par_align_pkg;
  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;
endpackage

// File: rtl/rx_ser2par_align_comma_detector.sv
// rx_ser2par_align_comma_detector: flags a 10-bit window holding K28.5 of either disparity.
module rx_ser2par_align_comma_detector
  import rx_ser2par_align_pkg::*;
(
  input  logic [9:0] sym,
  output logic       comma_hit
);
  assign comma_hit = (sym == K28_5_RDN) || (sym == K28_5_RDP);
endmodule

// File: rtl/rx_ser2par_align.sv
// rx_ser2par_align: bit-serial deserializer that aligns 10-bit symbols to K28.5 commas
// and tracks link lock through HUNT/CHECK/LOCKED.
module rx_ser2par_align
  import rx_ser2par_align_pkg::*;
#(
  parameter int LOCK_COMMAS = 4,
  parameter int LOSS_COMMAS = 4
) (
  input  logic       TRANSCLK,
  input  logic       Reset,
  input  logic       serial_in,
  output logic [9:0] symbol_out,
  output logic       symbol_valid,
  output logic       comma_det,
  output logic       LOCKED,
  output logic       realign
);
  localparam int CW = $clog2(LOCK_COMMAS > LOSS_COMMAS ? LOCK_COMMAS : LOSS_COMMAS) + 1;
  localparam logic [CW-1:0] LOCK_N = CW'(LOCK_COMMAS);
  localparam logic [CW-1:0] LOSS_N = CW'(LOSS_COMMAS);
  logic [9:0] win;
  logic [3:0] cnt;
  logic [CW-1:0] ccount, ccount_nx, miscnt, miscnt_nx;
  logic hit, boundary, emit, move;
  state_t state, state_nx;
  rx_ser2par_align_comma_detector u_comma (
    .sym      (win),
    .comma_hit(hit)
  );
  assign boundary = cnt == 4'd9;
  // move: a comma off the current boundary re-anchors the phase counter on it
  always_comb begin
    state_nx  = state;
    ccount_nx = ccount;
    miscnt_nx = miscnt;
    emit      = 1'b0;
    move      = 1'b0;
    case (state)
      ST_HUNT: if (hit) begin
        move      = 1'b1;
        ccount_nx = CW'(1);
        state_nx  = (LOCK_N == CW'(1)) ? ST_LOCKED : ST_CHECK;
      end
      ST_CHECK: if (boundary) begin
        emit = 1'b1;
        if (hit) begin
          ccount_nx = (ccount == LOCK_N) ? ccount : ccount + CW'(1);
          state_nx  = (ccount_nx == LOCK_N) ? ST_LOCKED : ST_CHECK;
        end
      end else if (hit) begin
        move      = 1'b1;
        ccount_nx = CW'(1);
      end
      ST_LOCKED: begin
        emit = boundary;
        if (hit && boundary) miscnt_nx = '0;
        else if (hit && (miscnt + CW'(1) >= LOSS_N)) begin
          state_nx  = ST_HUNT;
          miscnt_nx = '0;
          ccount_nx = '0;
        end else if (hit) miscnt_nx = miscnt + CW'(1);
      end
      default: state_nx = ST_HUNT;
    endcase
  end
  always_ff @(posedge TRANSCLK or negedge Reset)
    if (!Reset) begin
      win          <= '0;
      cnt          <= '0;
      ccount       <= '0;
      miscnt       <= '0;
      state        <= ST_HUNT;
      symbol_out   <= '0;
      symbol_valid <= 1'b0;
      comma_det    <= 1'b0;
      LOCKED       <= 1'b0;
      realign      <= 1'b0;
    end else begin
      win          <= {serial_in, win[9:1]};
      cnt          <= (boundary || move) ? 4'd0 : cnt + 4'd1;
      ccount       <= ccount_nx;
      miscnt       <= miscnt_nx;
      state        <= state_nx;
      if (emit || move) symbol_out <= win;
      symbol_valid <= emit || move;
      comma_det    <= move || (emit && hit);
      LOCKED       <= state_nx == ST_LOCKED;
      realign      <= move;
    end
endmodule
